mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer for the single-ported data memory in the MIPS pipeline. It shares the memory between requester 0 (pipeline MEM stage) and requester 1 (program/data loader), grants one transaction at a time with round-robin fairness, and drives the memory's chip-enable, read/write strobes, address and store data. It also waits out the memory read latency and returns load data with a one-cycle acknowledge.

## Interface
- DWIDTH, 32, data width
- AWIDTH_MEM, 32, memory address width
- RD_LAT, 1, cycles from memory read strobe edge to valid load data; legal range 1..15

- ar_clk  in  1  clock; all state changes on rising edge
- ar_rst  in  1  reset, asynchronous, active-high
- r0_req / r1_req  in  1  transaction request; held until ack
- r0_we / r1_we  in  1  1 = write, 0 = read; stable while req high
- r0_addr / r1_addr  in  AWIDTH_MEM  address; stable while req high
- r0_wdata / r1_wdata  in  DWIDTH  store data; stable while req high
- r0_ack / r1_ack  out  1  one-cycle completion pulse
- r0_rdata / r1_rdata  out  DWIDTH  load data; valid in the ack cycle of a read, held until the next read ack on that port
- ar_o_ce  out  1  memory chip enable
- ar_o_wr_en / ar_o_rd_en  out  1  memory write / read strobe
- ar_o_addr  out  AWIDTH_MEM  memory address
- ar_o_store_data  out  DWIDTH  memory store data
- ar_i_load_data  in  DWIDTH  memory load data
- ar_o_busy  out  1  high in every state except IDLE
- ar_o_owner  out  1  index of the current or most recent grant

## Operation
- States are IDLE, ISSUE, WAIT, and ACK.
- **IDLE:** if any req is high, select the winner, latch its we/addr/wdata, and go to ISSUE. Otherwise stay in IDLE.
- **Arbitration:**
  - If only one req is high, that port wins.
  - If both are high, the winner is the port that is not ar_o_owner.
  - ar_o_owner resets to 1, so port 0 wins the first tie.
- **ISSUE (1 cycle):**
  - ce = 1; wr_en = latched we; rd_en = !we.
  - ar_o_addr and ar_o_store_data come from the latched values.
  - Next state is ACK for a write, or WAIT for a read with the counter loaded to RD_LAT-1.
- **WAIT:**
  - ce = 1, strobes = 0.
  - When the counter is 0, capture ar_i_load_data into the owner's rdata and go to ACK. Otherwise decrement.
- **ACK (1 cycle):** assert the owner's ack, then go to IDLE. req is not sampled in ACK.
- Requesters drop req in the cycle after ack, or change it to a new request. A req still high in IDLE after ack starts a new transaction.
- All memory-side outputs are registered.
- ar_o_addr and ar_o_store_data hold their last value outside ISSUE; ce and strobes are 0 outside ISSUE/WAIT.
- Only one ack is high in any cycle. An ack goes to the latched owner only, never to the non-granted port.
- The we, addr and wdata of the losing port are ignored until it is granted.

## Timing
- **Reset values:**
  - all acks, ce, wr_en, rd_en and busy = 0
  - rdata, ar_o_addr and ar_o_store_data = 0
  - ar_o_owner = 1; state = IDLE; counter = 0
- **Write** (req first high in cycle 0 while IDLE): ISSUE in cycle 1 (wr_en = 1), ack in cycle 2. Latency from req to ack is 2 cycles.
- **Read:** ISSUE in cycle 1 (rd_en = 1), WAIT in cycles 2..1+RD_LAT, ack with rdata in cycle 2+RD_LAT. With RD_LAT = 1, ack is in cycle 3.
- Back-to-back transactions have one IDLE cycle between an ACK and the next ISSUE. Maximum throughput is one write per 3 cycles.
- If req rises while busy, it waits and is arbitrated in the next IDLE.
- **Simultaneous requests:** both reqs high in the same IDLE cycle are resolved by the round-robin rule. The loser's ISSUE follows the winner's ACK plus one IDLE cycle.
- **Reset mid-operation:**
  - Asserting ar_rst immediately (asynchronously) clears the strobes, ce and acks, and the FSM goes to IDLE.
  - The in-flight transaction is dropped with no ack. A write whose ISSUE edge has not yet occurred is not performed.
  - After ar_rst deasserts, arbitration restarts with port 0 preferred.

## Test plan
- **Single write, then read on port 0.** Stimulus: write addr 5, data 0xA5A5_0005, then read addr 5 with RD_LAT = 1. Required response: wr_en is high in exactly one cycle and ack 2 cycles after req; the read ack is 3 cycles after req with r0_rdata = 0xA5A5_0005.
- **Simultaneous requests after reset.** Stimulus: r0 writes addr 1 = 0x11 and r1 writes addr 2 = 0x22 in the same cycle. Required response: r0 is granted first (ack cycle 2) and r1 second (ack cycle 5); a read-back gives 0x11 and 0x22.
- **Round-robin fairness.** Stimulus: both reqs held continuously for 6 transactions. Required response: grants alternate 0,1,0,1,0,1; acks are never simultaneous; ar_o_owner tracks each grant.
- **Read latency parameter.** Stimulus: RD_LAT = 3, read of addr 9 holding 0x99. Required response: ack 5 cycles after req with rdata = 0x99; rd_en is high only in the ISSUE cycle.
- **Reset during WAIT.** Stimulus: assert ar_rst during a read's WAIT state. Required response: ce, strobes, acks and busy go to 0 immediately; no ack is issued; the next r1 request after reset completes normally.
- **rdata hold.** Stimulus: a port 0 read of 0x77 followed by a port 0 write. Required response: r0_rdata stays 0x77 through the write ack.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter and sequencer sharing one single-ported
// data memory between the pipeline MEM stage (port 0) and the loader (port 1).
// One transaction at a time: IDLE -> ISSUE -> [WAIT] -> ACK -> IDLE.
module mem_arbiter #(
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned AWIDTH_MEM = 32,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                  ar_clk,
  input  logic                  ar_rst,
  // requester 0 (MEM stage)
  input  logic                  r0_req,
  input  logic                  r0_we,
  input  logic [AWIDTH_MEM-1:0] r0_addr,
  input  logic [DWIDTH-1:0]     r0_wdata,
  output logic                  r0_ack,
  output logic [DWIDTH-1:0]     r0_rdata,
  // requester 1 (loader)
  input  logic                  r1_req,
  input  logic                  r1_we,
  input  logic [AWIDTH_MEM-1:0] r1_addr,
  input  logic [DWIDTH-1:0]     r1_wdata,
  output logic                  r1_ack,
  output logic [DWIDTH-1:0]     r1_rdata,
  // memory side
  output logic                  ar_o_ce,
  output logic                  ar_o_wr_en,
  output logic                  ar_o_rd_en,
  output logic [AWIDTH_MEM-1:0] ar_o_addr,
  output logic [DWIDTH-1:0]     ar_o_store_data,
  input  logic [DWIDTH-1:0]     ar_i_load_data,
  // status
  output logic                  ar_o_busy,
  output logic                  ar_o_owner
);

  // Wide enough for RD_LAT-1 with RD_LAT up to 15.
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  owner_q, owner_d;
  logic                  we_q, we_d;
  logic [AWIDTH_MEM-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0]     wdata_q, wdata_d;
  logic [DWIDTH-1:0]     rdata0_q, rdata0_d;
  logic [DWIDTH-1:0]     rdata1_q, rdata1_d;
  logic                  ce_q, ce_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic                  busy_q, busy_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic                  win;

  // Round-robin winner: on a tie the port that did not hold the last grant wins.
  always_comb begin
    win = 1'b0;
    if (r0_req && r1_req) begin
      win = ~owner_q;
    end else if (r1_req) begin
      win = 1'b1;
    end
  end

  // Next-state, latch and load-data capture logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      ST_IDLE: begin
        if (r0_req || r1_req) begin
          owner_d = win;
          we_d    = win ? r1_we    : r0_we;
          addr_d  = win ? r1_addr  : r0_addr;
          wdata_d = win ? r1_wdata : r0_wdata;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          state_d = ST_ACK;
        end else begin
          cnt_d   = CNT_W'(RD_LAT - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          if (owner_q) begin
            rdata1_d = ar_i_load_data;
          end else begin
            rdata0_d = ar_i_load_data;
          end
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered outputs decoded from the state being entered.
  always_comb begin
    ce_d    = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
    wr_en_d = (state_d == ST_ISSUE) && we_d;
    rd_en_d = (state_d == ST_ISSUE) && !we_d;
    busy_d  = (state_d != ST_IDLE);
    ack0_d  = (state_d == ST_ACK) && !owner_d;
    ack1_d  = (state_d == ST_ACK) && owner_d;
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge ar_clk or posedge ar_rst) begin
    if (ar_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      owner_q  <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      ce_q     <= 1'b0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      ce_q     <= ce_d;
      wr_en_q  <= wr_en_d;
      rd_en_q  <= rd_en_d;
      busy_q   <= busy_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
    end
  end

  // Latched address/data double as the held memory-side address/store data.
  assign ar_o_ce         = ce_q;
  assign ar_o_wr_en      = wr_en_q;
  assign ar_o_rd_en      = rd_en_q;
  assign ar_o_addr       = addr_q;
  assign ar_o_store_data = wdata_q;
  assign ar_o_busy       = busy_q;
  assign ar_o_owner      = owner_q;
  assign r0_ack          = ack0_q;
  assign r1_ack          = ack1_q;
  assign r0_rdata        = rdata0_q;
  assign r1_rdata        = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: randomized traffic on an RD_LAT=3 instance checked
// cycle by cycle against a transaction-level model, plus a directed
// write/read sequence on an RD_LAT=1 instance.
module tb_mem_arbiter;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned LAT = 3;

  logic ar_clk = 1'b0;
  logic ar_rst;
  always #5 ar_clk = ~ar_clk;

  // main instance (RD_LAT = LAT)
  logic          r0_req, r1_req, r0_we, r1_we;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic          r0_ack, r1_ack;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic          ce, wr_en, rd_en, busy, owner;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] store_data, load_data;

  mem_arbiter #(.DWIDTH(DW), .AWIDTH_MEM(AW), .RD_LAT(LAT)) u_dut (
    .ar_clk(ar_clk), .ar_rst(ar_rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .ar_o_ce(ce), .ar_o_wr_en(wr_en), .ar_o_rd_en(rd_en),
    .ar_o_addr(mem_addr), .ar_o_store_data(store_data),
    .ar_i_load_data(load_data), .ar_o_busy(busy), .ar_o_owner(owner)
  );

  // second instance (RD_LAT = 1), port 1 idle
  logic          b_r0_req, b_r0_we, b_r1_req, b_r1_we;
  logic [AW-1:0] b_r0_addr, b_r1_addr;
  logic [DW-1:0] b_r0_wdata, b_r1_wdata;
  logic          b_r0_ack, b_r1_ack;
  logic [DW-1:0] b_r0_rdata, b_r1_rdata;
  logic          b_ce, b_wr_en, b_rd_en, b_busy, b_owner;
  logic [AW-1:0] b_mem_addr;
  logic [DW-1:0] b_store_data, b_load_data;

  mem_arbiter #(.DWIDTH(DW), .AWIDTH_MEM(AW), .RD_LAT(1)) u_dut_lat1 (
    .ar_clk(ar_clk), .ar_rst(ar_rst),
    .r0_req(b_r0_req), .r0_we(b_r0_we), .r0_addr(b_r0_addr), .r0_wdata(b_r0_wdata),
    .r0_ack(b_r0_ack), .r0_rdata(b_r0_rdata),
    .r1_req(b_r1_req), .r1_we(b_r1_we), .r1_addr(b_r1_addr), .r1_wdata(b_r1_wdata),
    .r1_ack(b_r1_ack), .r1_rdata(b_r1_rdata),
    .ar_o_ce(b_ce), .ar_o_wr_en(b_wr_en), .ar_o_rd_en(b_rd_en),
    .ar_o_addr(b_mem_addr), .ar_o_store_data(b_store_data),
    .ar_i_load_data(b_load_data), .ar_o_busy(b_busy), .ar_o_owner(b_owner)
  );

  // Memory models: load data is valid only in the RD_LAT-th cycle after the strobe edge.
  logic [DW-1:0] mem_a [16];
  logic [3:0]    pa_addr;
  int            pa_cnt;
  logic [DW-1:0] mem_b [16];
  logic [3:0]    pb_addr;
  int            pb_cnt;

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    pa_cnt = 0; pa_addr = '0;
    pb_cnt = 0; pb_addr = '0;
  end

  always @(posedge ar_clk) begin
    if (ce && wr_en) mem_a[mem_addr[3:0]] <= store_data;
    if (ce && rd_en) begin
      pa_addr <= mem_addr[3:0];
      pa_cnt  <= LAT;
    end else if (pa_cnt > 0) begin
      pa_cnt <= pa_cnt - 1;
    end
    if (b_ce && b_wr_en) mem_b[b_mem_addr[3:0]] <= b_store_data;
    if (b_ce && b_rd_en) begin
      pb_addr <= b_mem_addr[3:0];
      pb_cnt  <= 1;
    end else if (pb_cnt > 0) begin
      pb_cnt <= pb_cnt - 1;
    end
  end

  assign load_data   = (pa_cnt == 1) ? mem_a[pa_addr] : 32'hDEAD_BEEF;
  assign b_load_data = (pb_cnt == 1) ? mem_b[pb_addr] : 32'hDEAD_BEEF;

  // Checking
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Requester state
  int            mode;           // 0: only posted requests, 1: always request, 2: random
  bit            pend  [2];
  bit            q_we  [2];
  logic [AW-1:0] q_addr[2];
  logic [DW-1:0] q_wd  [2];

  // Transaction-level reference model
  bit            has_txn;
  int            m_start, m_ack;
  bit            m_port, m_we;
  logic [DW-1:0] m_exp_rd;
  bit            m_owner;
  logic [AW-1:0] m_last_addr;
  logic [DW-1:0] m_last_wd;
  logic [DW-1:0] m_rd  [2];
  logic [DW-1:0] m_mem [16];
  int            n_grant[2];

  task automatic model_reset();
    has_txn     = 1'b0;
    m_owner     = 1'b1;
    m_last_addr = '0;
    m_last_wd   = '0;
    m_rd[0]     = '0;
    m_rd[1]     = '0;
    pend[0]     = 1'b0;
    pend[1]     = 1'b0;
  endtask

  task automatic check_cycle();
    bit in_t;
    in_t = has_txn && (cyc > m_start) && (cyc <= m_ack);
    if (in_t && cyc == m_ack && !m_we) m_rd[m_port] = m_exp_rd;
    check_eq("busy",   64'(busy),   64'(in_t));
    check_eq("ce",     64'(ce),     64'(in_t && cyc < m_ack));
    check_eq("wr_en",  64'(wr_en),  64'(in_t && cyc == m_start + 1 && m_we));
    check_eq("rd_en",  64'(rd_en),  64'(in_t && cyc == m_start + 1 && !m_we));
    check_eq("r0_ack", 64'(r0_ack), 64'(in_t && cyc == m_ack && m_port == 1'b0));
    check_eq("r1_ack", 64'(r1_ack), 64'(in_t && cyc == m_ack && m_port == 1'b1));
    check_eq("r0_rdata", 64'(r0_rdata), 64'(m_rd[0]));
    check_eq("r1_rdata", 64'(r1_rdata), 64'(m_rd[1]));
    check_eq("addr",     64'(mem_addr), 64'(m_last_addr));
    check_eq("store",    64'(store_data), 64'(m_last_wd));
    check_eq("owner",    64'(owner), 64'(m_owner));
  endtask

  task automatic drive();
    for (int p = 0; p < 2; p++) begin
      if (has_txn && m_ack == cyc - 1 && int'(m_port) == p) pend[p] = 1'b0;
      if (!pend[p] && (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0))) begin
        pend[p]   = 1'b1;
        q_we[p]   = 1'($urandom_range(0, 1));
        q_addr[p] = AW'($urandom_range(0, 15));
        q_wd[p]   = $urandom;
      end
    end
    r0_req = pend[0]; r0_we = q_we[0]; r0_addr = q_addr[0]; r0_wdata = q_wd[0];
    r1_req = pend[1]; r1_we = q_we[1]; r1_addr = q_addr[1]; r1_wdata = q_wd[1];
  endtask

  task automatic model_step();
    bit w;
    if ((!has_txn || cyc > m_ack) && (pend[0] || pend[1])) begin
      w           = (pend[0] && pend[1]) ? !m_owner : pend[1];
      has_txn     = 1'b1;
      m_start     = cyc;
      m_port      = w;
      m_we        = q_we[w];
      m_ack       = cyc + (m_we ? 2 : 2 + int'(LAT));
      m_owner     = w;
      m_last_addr = q_addr[w];
      m_last_wd   = q_wd[w];
      if (m_we) m_mem[m_last_addr[3:0]] = m_last_wd;
      else      m_exp_rd = m_mem[m_last_addr[3:0]];
      n_grant[w]++;
    end
  endtask

  task automatic tick();
    @(posedge ar_clk);
    cyc++;
    @(negedge ar_clk);
    check_cycle();
    drive();
    model_step();
  endtask

  task automatic post(input int p, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    pend[p] = 1'b1; q_we[p] = we; q_addr[p] = addr; q_wd[p] = wd;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      tick();
      done = !pend[0] && !pend[1] && (!has_txn || cyc > m_ack);
    end
    if (!done) check_eq("drain_timeout", 64'(0), 64'(1));
  endtask

  // Global time bound
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int wr_cnt, ack_cnt;
    ar_rst = 1'b1;
    r0_req = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
    r1_req = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
    b_r0_req = 0; b_r0_we = 0; b_r0_addr = '0; b_r0_wdata = '0;
    b_r1_req = 0; b_r1_we = 0; b_r1_addr = '0; b_r1_wdata = '0;
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    n_grant[0] = 0; n_grant[1] = 0;
    mode = 0;
    model_reset();
    repeat (3) @(negedge ar_clk);
    ar_rst = 1'b0;

    // RD_LAT=1 instance: write addr 5 then read it back.
    b_r0_req = 1; b_r0_we = 1; b_r0_addr = 5; b_r0_wdata = 32'hA5A5_0005;
    wr_cnt = 0; ack_cnt = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge ar_clk);
      wr_cnt  += int'(b_wr_en);
      ack_cnt += int'(b_r0_ack) + int'(b_r1_ack);
      if (k == 1) check_eq("b_wr_issue", 64'(b_wr_en), 64'(1));
      if (k == 1) check_eq("b_ack_early", 64'(b_r0_ack), 64'(0));
      if (k == 2) check_eq("b_wr_ack", 64'(b_r0_ack), 64'(1));
      if (k == 3) b_r0_we = 0;
      if (k == 4) check_eq("b_rd_issue", 64'(b_rd_en), 64'(1));
      if (k == 5) check_eq("b_rd_ack_early", 64'(b_r0_ack), 64'(0));
      if (k == 6) begin
        check_eq("b_rd_ack", 64'(b_r0_ack), 64'(1));
        check_eq("b_rdata", 64'(b_r0_rdata), 64'(32'hA5A5_0005));
        b_r0_req = 0;
      end
    end
    check_eq("b_wr_cycles", 64'(wr_cnt), 64'(1));
    check_eq("b_ack_count", 64'(ack_cnt), 64'(2));

    // Main instance: both ports requesting continuously from reset, then random.
    mode = 1;
    repeat (30) tick();
    check_eq("fair_p0_ge", 64'(n_grant[0] >= 3), 64'(1));
    check_eq("fair_balance", 64'(n_grant[0] - n_grant[1] <= 1 && n_grant[1] - n_grant[0] <= 1), 64'(1));
    mode = 2;
    repeat (400) tick();
    mode = 0;
    drain();

    // Port 0 read data must survive a following write.
    post(0, 1'b1, 3, 32'h77); drain();
    post(0, 1'b0, 3, 32'h0);  drain();
    post(0, 1'b1, 4, 32'h1234); drain();
    check_eq("rdata_hold", 64'(r0_rdata), 64'(32'h77));

    // Reset during a read's WAIT state.
    post(0, 1'b1, 9, 32'h99); drain();
    post(0, 1'b0, 9, 32'h0);
    begin
      bit hit;
      hit = 1'b0;
      for (int k = 0; k < 10 && !hit; k++) begin
        tick();
        hit = has_txn && !m_we && (cyc == m_start + 2);
      end
      check_eq("reach_wait", 64'(hit), 64'(1));
    end
    #1 ar_rst = 1'b1;
    #1;
    check_eq("rst_ce",    64'(ce),     64'(0));
    check_eq("rst_rd_en", 64'(rd_en),  64'(0));
    check_eq("rst_wr_en", 64'(wr_en),  64'(0));
    check_eq("rst_busy",  64'(busy),   64'(0));
    check_eq("rst_acks",  64'({r0_ack, r1_ack}), 64'(0));
    model_reset();
    r0_req = 0; r1_req = 0;
    repeat (2) begin
      @(negedge ar_clk);
      cyc++;
      check_eq("rst_hold_ack", 64'({r0_ack, r1_ack}), 64'(0));
    end
    ar_rst = 1'b0;
    check_eq("rst_owner", 64'(owner), 64'(1));
    post(1, 1'b0, 9, 32'h0);
    drain();
    check_eq("post_rst_r1", 64'(r1_rdata), 64'(32'h99));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
